// File: rtl/digit_scan_ctrl_if.sv
// digit_scan_ctrl_if: digit inputs, scan controls and latched/anode outputs of the display scanner
interface digit_scan_ctrl_if;
    logic       en;
    logic       blank_lead;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] d_tens;
    logic [3:0] d_ones;
    logic       s0;
    logic [1:0] an;
    logic       frame_done;
    modport master (
        output en, blank_lead, tens, ones,
        input  d_tens, d_ones, s0, an, frame_done
    );
    modport slave (
        input  en, blank_lead, tens, ones,
        output d_tens, d_ones, s0, an, frame_done
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: two-digit 7-segment scanner with per-frame latch, guard intervals and leading-zero blanking
module digit_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input logic clk,
    input logic rst_n,
    digit_scan_ctrl_if.slave bus
);
    localparam int MAXN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW = $clog2(MAXN) + 1;
    localparam logic [CW-1:0] LR = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] LB = CW'(BLANK_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, ONES_GUARD, ONES_ON, TENS_GUARD, TENS_ON} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic blank;
    assign blank = bus.blank_lead && bus.d_tens == 4'd0;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.s0         <= 1'b0;
            bus.an         <= 2'b11;
            bus.d_tens     <= 4'd0;
            bus.d_ones     <= 4'd0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= state == TENS_ON && cnt == LR;
            // dropping en aborts the frame from any active state
            if (state != IDLE && !bus.en) begin
                state  <= IDLE;
                cnt    <= '0;
                bus.an <= 2'b11;
                bus.s0 <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (bus.en) begin
                        state      <= ONES_GUARD;
                        cnt        <= '0;
                        bus.d_ones <= bus.ones;
                        bus.d_tens <= bus.tens;
                    end
                    ONES_GUARD: if (cnt == LB) begin
                        state  <= ONES_ON;
                        cnt    <= '0;
                        bus.an <= 2'b10;
                    end else cnt <= cnt + 1'b1;
                    ONES_ON: if (cnt == LR) begin
                        state  <= TENS_GUARD;
                        cnt    <= '0;
                        bus.an <= 2'b11;
                        bus.s0 <= 1'b1;
                    end else cnt <= cnt + 1'b1;
                    TENS_GUARD: if (cnt == LB) begin
                        state  <= TENS_ON;
                        cnt    <= '0;
                        bus.an <= blank ? 2'b11 : 2'b01;
                    end else cnt <= cnt + 1'b1;
                    TENS_ON: if (cnt == LR) begin
                        state      <= ONES_GUARD;
                        cnt        <= '0;
                        bus.an     <= 2'b11;
                        bus.s0     <= 1'b0;
                        bus.d_ones <= bus.ones;
                        bus.d_tens <= bus.tens;
                    end else begin
                        cnt    <= cnt + 1'b1;
                        bus.an <= blank ? 2'b11 : 2'b01;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
